// File: rtl/pattern_sequencer.sv
// Pattern sequencer: UART command decode, frame-synchronous pattern
// select, auto-cycle stepping and one-byte ASCII acknowledge.
module pattern_sequencer #(
    parameter int FRAMES_PER_STEP = 60
) (
    input  logic       CLK,
    input  logic       i_Reset,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    input  logic       i_VSync,
    input  logic       i_TX_Active,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    output logic       o_SW1,
    output logic       o_SW2,
    output logic       o_SW3,
    output logic       o_SW4,
    output logic       o_Auto,
    output logic       o_Pending
);

    localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {
        PAT_K = 2'd0,
        PAT_R = 2'd1,
        PAT_G = 2'd2,
        PAT_B = 2'd3
    } pat_t;

    function automatic logic [7:0] ack_of(input pat_t p);
        unique case (p)
            PAT_R:   return 8'h52;
            PAT_G:   return 8'h47;
            PAT_B:   return 8'h42;
            default: return 8'h4B;
        endcase
    endfunction

    function automatic logic [3:0] onehot_of(input pat_t p);
        unique case (p)
            PAT_R:   return 4'b0001;
            PAT_G:   return 4'b0010;
            PAT_B:   return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    logic          vsync_q;
    pat_t          cur, cur_n;
    pat_t          pend, pend_n;
    logic          pend_v, pend_v_n;
    logic          auto_q, auto_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ack_full, ack_full_n;
    logic [7:0]    ack_byte, ack_byte_n;
    logic          tx_dv, tx_dv_n;
    logic [7:0]    tx_byte, tx_byte_n;
    logic [3:0]    sw, sw_n;

    logic          tick;
    logic          is_star;
    logic          is_pat;
    logic          send;
    logic          pat_ack;
    pat_t          rx_pat;

    // Frame edge detect and command byte decode.
    always_comb begin
        tick    = vsync_q & ~i_VSync;
        is_star = i_RX_DV & (i_RX_Byte == 8'h2A);
        is_pat  = i_RX_DV & ~is_star;
        unique case (i_RX_Byte[3:0])
            4'h1:    rx_pat = PAT_R;
            4'h2:    rx_pat = PAT_G;
            4'h3:    rx_pat = PAT_B;
            default: rx_pat = PAT_K;
        endcase
    end

    // Next-state: ack send, tick application, mode toggle, pending capture.
    always_comb begin
        cur_n      = cur;
        pend_n     = pend;
        pend_v_n   = pend_v;
        auto_n     = auto_q;
        cnt_n      = cnt;
        ack_full_n = ack_full;
        ack_byte_n = ack_byte;
        tx_byte_n  = tx_byte;
        pat_ack    = 1'b0;

        // The queued byte leaves before any new ack of this cycle lands.
        send    = ack_full & ~i_TX_Active & ~tx_dv;
        tx_dv_n = send;
        if (send) begin
            tx_byte_n  = ack_byte;
            ack_full_n = 1'b0;
        end

        if (tick) begin
            if (pend_v) begin
                cur_n    = pend;
                pend_v_n = 1'b0;
                cnt_n    = '0;
                pat_ack  = 1'b1;
            end else if (auto_q) begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    cur_n   = pat_t'(cur + 2'd1);
                    pat_ack = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end else begin
                cnt_n = '0;
            end
        end

        if (is_star) begin
            auto_n = ~auto_q;
            cnt_n  = '0;
            if (!pat_ack) begin
                ack_full_n = 1'b1;
                ack_byte_n = auto_q ? 8'h4D : 8'h41;
            end
        end

        if (is_pat) begin
            pend_n   = rx_pat;
            pend_v_n = 1'b1;
        end

        if (pat_ack) begin
            ack_full_n = 1'b1;
            ack_byte_n = ack_of(cur_n);
        end

        sw_n = onehot_of(cur_n);
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (i_Reset) begin
            vsync_q  <= 1'b1;
            cur      <= PAT_K;
            pend     <= PAT_K;
            pend_v   <= 1'b0;
            auto_q   <= 1'b0;
            cnt      <= '0;
            ack_full <= 1'b0;
            ack_byte <= 8'h00;
            tx_dv    <= 1'b0;
            tx_byte  <= 8'h00;
            sw       <= 4'b1000;
        end else begin
            vsync_q  <= i_VSync;
            cur      <= cur_n;
            pend     <= pend_n;
            pend_v   <= pend_v_n;
            auto_q   <= auto_n;
            cnt      <= cnt_n;
            ack_full <= ack_full_n;
            ack_byte <= ack_byte_n;
            tx_dv    <= tx_dv_n;
            tx_byte  <= tx_byte_n;
            sw       <= sw_n;
        end
    end

    assign o_SW1     = sw[0];
    assign o_SW2     = sw[1];
    assign o_SW3     = sw[2];
    assign o_SW4     = sw[3];
    assign o_Auto    = auto_q;
    assign o_Pending = pend_v;
    assign o_TX_DV   = tx_dv;
    assign o_TX_Byte = tx_byte;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: reference model with ack scoreboard,
// directed scenarios followed by randomized frames and commands.
module tb_pattern_sequencer;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       vsync;
    logic       tx_active;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       sw1, sw2, sw3, sw4;
    logic       auto_m, pending;

    int tests = 0;
    int fails = 0;

    byte unsigned sb[$];

    // Reference model state (pattern K=0 R=1 G=2 B=3)
    int           m_pat, m_pend, m_cnt;
    bit           m_pend_v, m_auto, m_full, m_last_dv, m_vs;
    byte unsigned m_qb, m_txb;

    always #5 clk = ~clk;

    pattern_sequencer #(.FRAMES_PER_STEP(N)) dut (
        .CLK         (clk),
        .i_Reset     (rst),
        .i_RX_DV     (rx_dv),
        .i_RX_Byte   (rx_byte),
        .i_VSync     (vsync),
        .i_TX_Active (tx_active),
        .o_TX_DV     (tx_dv),
        .o_TX_Byte   (tx_byte),
        .o_SW1       (sw1),
        .o_SW2       (sw2),
        .o_SW3       (sw3),
        .o_SW4       (sw4),
        .o_Auto      (auto_m),
        .o_Pending   (pending)
    );

    function automatic byte unsigned ack_for(input int p);
        case (p)
            1:       return 8'h52;
            2:       return 8'h47;
            3:       return 8'h42;
            default: return 8'h4B;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        m_pat = 0; m_pend = 0; m_cnt = 0;
        m_pend_v = 0; m_auto = 0; m_full = 0; m_last_dv = 0; m_vs = 1;
        m_qb = 0; m_txb = 0;
    endtask

    // One clock of the reference behaviour, from the inputs seen at the edge.
    task automatic model_step();
        bit tick, sent, pack;
        int nib;
        if (rst) begin
            model_reset();
            return;
        end
        tick = m_vs && !vsync;
        sent = m_full && !tx_active && !m_last_dv;
        pack = 0;
        if (sent) begin
            sb.push_back(m_qb);
            m_txb  = m_qb;
            m_full = 0;
        end
        if (tick) begin
            if (m_pend_v) begin
                m_pat = m_pend; m_pend_v = 0; m_cnt = 0; pack = 1;
            end else if (m_auto) begin
                if (m_cnt == N - 1) begin
                    m_cnt = 0; m_pat = (m_pat + 1) % 4; pack = 1;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_cnt = 0;
            end
        end
        if (rx_dv && rx_byte == 8'h2A) begin
            m_auto = !m_auto;
            m_cnt  = 0;
            if (!pack) begin
                m_full = 1;
                m_qb   = m_auto ? 8'h41 : 8'h4D;
            end
        end else if (rx_dv) begin
            nib      = int'(rx_byte[3:0]);
            m_pend   = (nib >= 1 && nib <= 3) ? nib : 0;
            m_pend_v = 1;
        end
        if (pack) begin
            m_full = 1;
            m_qb   = ack_for(m_pat);
        end
        m_vs      = vsync;
        m_last_dv = sent;
    endtask

    // Apply current drives for one clock, then compare against the model.
    task automatic clk1();
        logic [3:0] exp_sw;
        @(posedge clk);
        model_step();
        @(negedge clk);
        exp_sw = (m_pat == 0) ? 4'b1000 : (4'b0001 << (m_pat - 1));
        check("sw", {sw4, sw3, sw2, sw1}, exp_sw);
        check("auto", auto_m, m_auto);
        check("pending", pending, m_pend_v);
        check("tx_dv", tx_dv, m_last_dv);
        check("tx_byte", tx_byte, m_txb);
        rx_dv = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        clk1();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clk1();
    endtask

    task automatic frame(input int hi, input int lo);
        vsync = 1'b1;
        idle(hi);
        vsync = 1'b0;
        idle(lo);
        vsync = 1'b1;
    endtask

    // Scoreboard monitor: every strobe must match the next predicted ack.
    always @(negedge clk) begin
        if (tx_dv === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_unexpected: got %0h expected none at %0t",
                         tx_byte, $time);
            end else begin
                check("tx_sb", tx_byte, sb.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
        vsync = 1'b1; tx_active = 1'b0;
        model_reset();
        idle(2);
        rst = 1'b0;
        idle(1);
        check("reset_sw", {sw4, sw3, sw2, sw1}, 4'b1000);
        check("reset_txb", tx_byte, 8'h00);

        // No commands: frames pass with no change and no ack
        for (int f = 0; f < 3; f++) frame(6, 2);

        // Single manual select
        idle(2);
        send_rx(8'h61);
        check("pend_set", pending, 1'b1);
        idle(2);
        frame(1, 2);
        idle(4);

        // Last write wins
        send_rx(8'h32);
        idle(1);
        send_rx(8'h23);
        frame(2, 2);
        check("last_wins", {sw4, sw3, sw2, sw1}, 4'b0100);
        idle(4);

        // Auto mode from R through a full cycle, then off
        send_rx(8'h31);
        frame(2, 2);
        idle(4);
        send_rx(8'h2A);
        idle(3);
        for (int f = 0; f < 13; f++) frame(5, 2);
        send_rx(8'h2A);
        idle(3);
        for (int f = 0; f < 4; f++) frame(5, 2);

        // New byte coincident with tick while another is pending
        send_rx(8'h31);
        idle(3);
        vsync = 1'b0;
        send_rx(8'h62);
        check("coinc_pend", pending, 1'b1);
        idle(2);
        frame(3, 2);
        idle(4);

        // Two acks while TX busy: only the later one goes out
        tx_active = 1'b1;
        send_rx(8'h33);
        frame(2, 2);
        send_rx(8'h2A);
        idle(3);
        tx_active = 1'b0;
        idle(5);
        send_rx(8'h2A);
        idle(4);

        // Reset with a selection pending
        send_rx(8'h31);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        check("rst_pend", pending, 1'b0);
        check("rst_sw", {sw4, sw3, sw2, sw1}, 4'b1000);
        idle(3);

        // Randomized frames, commands and TX backpressure
        for (int f = 0; f < 250; f++) begin
            int hi, lo;
            hi = $urandom_range(3, 10);
            lo = $urandom_range(1, 3);
            for (int c = 0; c < hi + lo; c++) begin
                vsync = (c < hi) ? 1'b1 : 1'b0;
                if ($urandom_range(0, 5) == 0) tx_active = ~tx_active;
                rst = ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0;
                if ($urandom_range(0, 4) == 0) begin
                    rx_dv   = 1'b1;
                    rx_byte = ($urandom_range(0, 5) == 0) ?
                              8'h2A : 8'($urandom_range(0, 255));
                end
                clk1();
            end
        end
        rst = 1'b0;
        vsync = 1'b1;
        tx_active = 1'b0;
        idle(10);
        check("sb_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Controller for the VGA pattern generator: decodes UART RX bytes into its one-hot switch selects (SW1 red, SW2 green, SW3 blue, SW4 black).
- Applies changes only at frame boundaries to prevent mid-frame tearing.
- Provides an auto-cycle mode that steps the pattern every N frames.
- Returns a one-byte ASCII acknowledge through the UART TX handshake.
- Sits between the UART RX/TX and the pattern generator in the VGA_UART top level.

Parameters:
FRAMES_PER_STEP, 60, frames per pattern step in auto mode (>=1); counter width is derived from it.

Ports:
CLK  input  1  system/pixel clock
i_Reset  input  1  synchronous, active-high reset
i_RX_DV  input  1  one-cycle strobe, i_RX_Byte valid
i_RX_Byte  input  8  received command byte
i_VSync  input  1  vertical sync from the sync generator; low during the sync pulse
i_TX_Active  input  1  UART TX busy
o_TX_DV  output  1  one-cycle strobe to UART TX
o_TX_Byte  output  8  acknowledge byte
o_SW1  output  1  red select
o_SW2  output  1  green select
o_SW3  output  1  blue select
o_SW4  output  1  black select
o_Auto  output  1  auto-cycle mode active
o_Pending  output  1  manual selection waiting for frame boundary

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - o_SW4=1; o_SW1, o_SW2, o_SW3 = 0 (current pattern = K).
  - o_Auto=0, o_Pending=0, o_TX_DV=0, o_TX_Byte=0x00.
  - Frame counter 0; ack queue empty; r_VSync=1.
- Reset asserted mid-operation discards the pending selection and any queued ack; no ack is emitted.
- Pattern encoding:
  - K=0, R=1, G=2, B=3.
  - SW outputs are one-hot of the current pattern and registered; exactly one is high at all times.
- Frame tick:
  - r_VSync registers i_VSync each cycle.
  - tick = r_VSync & ~i_VSync.
  - Effects of a tick land on the same clock edge at which i_VSync is first sampled low.
- Decode on i_RX_DV=1:
  - 0x2A ('*'): toggle o_Auto on the next edge, clear the frame counter, queue ack 'A' (0x41) if turning on or 'M' (0x4D) if turning off. Pending state is unaffected.
  - Otherwise, by low nibble: 1 -> R, 2 -> G, 3 -> B, any other value -> K.
  - The decoded pattern goes into the pending register; o_Pending=1 on the next edge.
  - A new byte while pending overwrites the pending value (last wins).
- On tick:
  - If pending: current <= pending, o_Pending <= 0, frame counter <= 0, queue ack.
  - Else if o_Auto:
    - counter == FRAMES_PER_STEP-1: counter <= 0, current advances R->G->B->K->R, queue ack.
    - Otherwise: counter increments.
  - Else: counter stays 0.
- Ack bytes: K=0x4B, R=0x52, G=0x47, B=0x42.
- Simultaneous events:
  - RX pattern byte and tick in the same cycle: the tick applies the old pending value (if any); the new byte becomes pending for the next frame. If nothing was pending, the tick takes the auto path and the byte becomes pending.
  - '*' and tick in the same cycle: auto toggles and the counter clears; the pending application still occurs. Pattern ack wins the queue.
- Ack queue:
  - Single entry; a newer ack overwrites an unsent one.
  - Sent when the queue is full, i_TX_Active=0, and o_TX_DV was 0 in the previous cycle (minimum 2-cycle spacing).
  - Send means o_TX_DV=1 for exactly one cycle with o_TX_Byte loaded; the queue empties.
  - o_TX_Byte holds its last value otherwise.
- Latency:
  - RX_DV -> o_Pending: 1 clock.
  - Frame edge -> SW outputs: 1 clock.
  - SW change -> o_TX_DV: 1 clock minimum when TX is idle.
- Auto mode with FRAMES_PER_STEP=1 steps on every tick.

Test Plan:
1. Reset, then 1 clock -> o_SW4=1, others 0; o_Auto=0; o_TX_DV=0; i_VSync toggling for 3 frames causes no change and no ack.
2. RX 0x61 ('a') mid-frame -> o_Pending=1 next cycle, SW unchanged until i_VSync falls, then o_SW1=1 and o_Pending=0; o_TX_DV pulses once with 0x52.
3. RX 0x32 then 0x23 before a frame edge -> at the edge o_SW3=1 (last wins); exactly one ack 0x42.
4. FRAMES_PER_STEP=3; RX 0x2A -> o_Auto=1, ack 0x41. From R, 3 ticks -> G, 6 -> B, 9 -> K, 12 -> R, with an ack per step. Second 0x2A -> o_Auto=0, ack 0x4D, pattern frozen.
5. RX_DV 0x62 on the same cycle as a tick with 0x31 pending -> R applied that edge; G pending and applied at the next tick.
6. i_TX_Active=1 while two acks are queued -> only the later byte is sent once i_TX_Active drops. Assert i_Reset with pending set -> all reset values restored and no TX strobe.
